uart_byte_tx: RTL and testbench

- UART serializer sitting directly downstream of the SDRAM read-FIFO drain stage.
- Accepts one byte per single-cycle `tx_flag` strobe on `tx_data` and transmits it LSB-first on `tx` as an 8N1 frame, or 8O1/8E1 when parity is enabled.
- A 2-entry holding buffer absorbs phase offset between the upstream byte strobe and frame boundaries, so back-to-back bytes go out with no idle gap.
- Drops and overflows are reported, never stalled: the upstream stage has no backpressure input.

---
 rtl/uart_byte_tx.sv | 159 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1/8O1/8E1 UART serializer with 2-entry holding buffer.
// Never stalls upstream; drops are flagged on the sticky ovf output.
module uart_byte_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_flag,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic        ovf,
  output logic [15:0] byte_cnt
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
  localparam logic [12:0] BAUD_MAX = 13'(BAUD_CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]  mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        push;
  logic        pop;
  logic        drop;
  logic [12:0] baud_cnt;
  logic        bit_end;
  logic        frame_end;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic        par_bit;
  logic        tx_nx;

  assign bit_end   = (state != IDLE) && (baud_cnt == BAUD_MAX);
  assign frame_end = (state == STOP) && bit_end;
  // Pop in IDLE, or on the last stop cycle so frames run back-to-back.
  assign pop  = (cnt != 2'd0) && ((state == IDLE) || frame_end);
  // A same-edge pop frees a slot even when the buffer is full.
  assign push = tx_flag && ((cnt != 2'd2) || pop);
  assign drop = tx_flag && !push;

  // Holding buffer storage; stale contents are harmless once cnt is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Holding buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pop) state_nx = START;
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7))
          state_nx = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (bit_end) state_nx = pop ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: next shift value and the line level for the next cycle.
  always_comb begin
    shift_nx = shift;
    if (pop)
      shift_nx = mem[rd_ptr];
    else if ((state == DATA) && bit_end)
      shift_nx = {1'b0, shift[7:1]};
    unique case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      PARITY:  tx_nx = par_bit;
      default: tx_nx = 1'b1;
    endcase
  end

  // Shift register, parity latch, bit index and baud counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= 8'h00;
      par_bit  <= 1'b0;
      bit_idx  <= 3'd0;
      baud_cnt <= 13'd0;
    end else begin
      shift <= shift_nx;
      if (pop) par_bit <= (^mem[rd_ptr]) ^ PARITY_ODD;
      if ((state == IDLE) || bit_end) baud_cnt <= 13'd0;
      else                            baud_cnt <= baud_cnt + 13'd1;
      if (state != DATA) bit_idx <= 3'd0;
      else if (bit_end)  bit_idx <= bit_idx + 3'd1;
    end
  end

  // Registered outputs: glitch-free line, status and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      ovf      <= 1'b0;
      byte_cnt <= 16'h0000;
    end else begin
      tx      <= tx_nx;
      busy    <= (state != IDLE) || (cnt != 2'd0);
      tx_done <= frame_end;
      if (drop)      ovf      <= 1'b1;
      if (frame_end) byte_cnt <= byte_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench for uart_byte_tx.
// Short bit period keeps every frame cheap to simulate.
module tb_uart_byte_tx;

  localparam int CLKF  = 160;
  localparam int BAUDR = 10;
  localparam int BITC  = CLKF / BAUDR;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         contig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        tx_flag;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic        ovf;
  logic [15:0] byte_cnt;

  logic [7:0]  tx_data_p;
  logic        tx_flag_p;
  logic        tx_po, busy_po, tx_done_po, ovf_po;
  logic        tx_pe, busy_pe, tx_done_pe, ovf_pe;
  logic [15:0] byte_cnt_po, byte_cnt_pe;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_push = 0;
  int          n_seen = 0;
  bit          mon_off = 1'b0;
  logic [15:0] exp_bc = 16'h0000;
  exp_t        sb[$];

  uart_byte_tx #(.CLK_FREQ(CLKF), .BAUD(BAUDR)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_flag(tx_flag),
    .tx(tx), .busy(busy), .tx_done(tx_done), .ovf(ovf),
    .byte_cnt(byte_cnt)
  );

  uart_byte_tx #(
    .CLK_FREQ(CLKF), .BAUD(BAUDR), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) dut_po (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_p), .tx_flag(tx_flag_p),
    .tx(tx_po), .busy(busy_po), .tx_done(tx_done_po), .ovf(ovf_po),
    .byte_cnt(byte_cnt_po)
  );

  uart_byte_tx #(
    .CLK_FREQ(CLKF), .BAUD(BAUDR), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut_pe (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_p), .tx_flag(tx_flag_p),
    .tx(tx_pe), .busy(busy_pe), .tx_done(tx_done_pe), .ovf(ovf_pe),
    .byte_cnt(byte_cnt_pe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input bit expect_it,
                        input bit chk_start, input bit contig);
    exp_t e;
    tx_data = d;
    tx_flag = 1'b1;
    if (expect_it) begin
      e.data   = d;
      e.start  = chk_start ? cyc + 2 : -1;
      e.contig = contig;
      sb.push_back(e);
      n_push++;
    end
    @(negedge clk);
    tx_flag = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000 && (n_seen != n_push || busy !== 1'b0); i++)
      @(negedge clk);
    check(name, (i < 3000), 1);
  endtask

  // Monitor: decode each frame from tx and compare against the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [9:0] fr;
    logic       act;
    bit         have;
    have = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (!mon_off && rst_n === 1'b1 && tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_frame", 1, 0);
          repeat (10 * BITC) @(negedge clk);
        end else begin
          e = sb.pop_front();
          if (e.start >= 0) check("frame_start_cycle", cyc, e.start);
          if (e.contig) check("b2b_no_gap_tx_done", tx_done, 1);
          fr = {1'b1, e.data, 1'b0};
          for (int k = 0; k < 10; k++) begin
            act = fr[k];
            for (int j = 0; j < BITC; j++) begin
              if (k != 0 || j != 0) @(negedge clk);
              if (tx !== fr[k]) act = tx;
              if (k == 9 && j == BITC - 1)
                check("tx_done_early", tx_done, 0);
            end
            check($sformatf("bit%0d_of_%02h", k, e.data), act, fr[k]);
          end
          @(negedge clk);
          check("tx_done_pulse", tx_done, 1);
          exp_bc = exp_bc + 16'h0001;
          check("byte_cnt", byte_cnt, exp_bc);
          n_seen++;
          have = 1'b1;
        end
      end
    end
  end

  initial begin : stim
    int  t;
    int  s;
    bit  found;
    bit  bad;
    rst_n     = 1'b0;
    tx_data   = 8'h00;
    tx_flag   = 1'b0;
    tx_data_p = 8'h00;
    tx_flag_p = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_byte_cnt", byte_cnt, 0);

    // Single byte.
    strobe(8'h55, 1, 1, 0);
    drain("single_drain");
    check("single_busy_after", busy, 0);

    // Back-to-back bytes spaced 10 cycles.
    strobe(8'hA5, 1, 1, 0);
    repeat (9) @(negedge clk);
    strobe(8'h3C, 1, 0, 1);
    repeat (9) @(negedge clk);
    strobe(8'hFF, 1, 0, 1);
    drain("b2b_drain");
    check("b2b_ovf", ovf, 0);

    // Overflow: fourth consecutive strobe is dropped.
    strobe(8'h01, 1, 1, 0);
    strobe(8'h02, 1, 0, 1);
    strobe(8'h03, 1, 0, 1);
    strobe(8'h04, 0, 0, 0);
    check("ovf_set", ovf, 1);
    drain("ovf_drain");
    check("ovf_sticky", ovf, 1);

    // Counter wrap.
    force dut.byte_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.byte_cnt;
    exp_bc = 16'hFFFF;
    check("wrap_preload", byte_cnt, 16'hFFFF);
    strobe(8'h81, 1, 1, 0);
    drain("wrap_drain");
    check("wrap_zero", byte_cnt, 16'h0000);

    // Parity: odd and even instances transmit 0x07 together.
    tx_data_p = 8'h07;
    tx_flag_p = 1'b1;
    t = cyc;
    @(negedge clk);
    tx_flag_p = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx_po === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("par_start_found", found, 1);
    if (found) begin
      s = cyc;
      check("par_start_cycle", s, t + 2);
      repeat (9 * BITC + BITC / 2) @(negedge clk);
      check("par_odd_bit", tx_po, 0);
      check("par_even_bit", tx_pe, 1);
      repeat (11 * BITC - 1 - (9 * BITC + BITC / 2)) @(negedge clk);
      check("par_stop_odd", tx_po, 1);
      check("par_done_early", tx_done_pe, 0);
      @(negedge clk);
      check("par_len_odd", tx_done_po, 1);
      check("par_len_even", tx_done_pe, 1);
      check("par_byte_cnt", byte_cnt_po, 1);
    end

    // Reset during DATA bit 3 with two bytes buffered.
    mon_off = 1'b1;
    strobe(8'h00, 0, 0, 0);
    strobe(8'hAA, 0, 0, 0);
    strobe(8'h55, 0, 0, 0);
    repeat (4 * BITC + 2) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_byte_cnt", byte_cnt, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (12 * BITC) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("post_rst_quiet", bad, 0);
    sb.delete();
    n_push = 0;
    n_seen = 0;
    exp_bc = 16'h0000;
    mon_off = 1'b0;
    strobe(8'hC3, 1, 1, 0);
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
